// File: rtl/iir_freq_resp_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : iir_freq_resp_engine_if
//  Description : Result stream of the IIR frequency-response engine.
//                Complex numerator/denominator pair per sweep point, with
//                valid/ready flow control and the index of the point shown.
//  Revision    : 1.0 - initial release
// ============================================================================
interface iir_freq_resp_engine_if #(
    parameter int BITS      = 16,
    parameter int ADDR_BITS = 11
);
    logic [BITS-1:0]      num_real;
    logic [BITS-1:0]      num_imag;
    logic [BITS-1:0]      den_real;
    logic [BITS-1:0]      den_imag;
    logic                 out_valid;
    logic                 out_ready;
    logic [ADDR_BITS-1:0] point_idx;

    // Producer side: the engine
    modport master (
        output num_real,
        output num_imag,
        output den_real,
        output den_imag,
        output out_valid,
        output point_idx,
        input  out_ready
    );

    // Consumer side: the downstream vectoring stage
    modport slave (
        input  num_real,
        input  num_imag,
        input  den_real,
        input  den_imag,
        input  out_valid,
        input  point_idx,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/iir_freq_resp_engine.sv
`default_nettype none
// ============================================================================
//  Module      : iir_freq_resp_engine
//  Description : Sweeps a phase table and evaluates B(e^jt) and A(e^jt) of an
//                order-N IIR filter by per-tap multiply-accumulate against an
//                external sin/cos unit (1-cycle latency). Results leave over
//                a valid/ready stream.
//                Build option: define SATURATE_EN to clamp out-of-range
//                results instead of keeping the low BITS bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module iir_freq_resp_engine #(
    parameter int BITS         = 16,
    parameter int FRAC_BITS    = 13,
    parameter int PHASE_BITS   = 16,
    parameter int FILTER_ORDER = 2,
    parameter int ADDR_BITS    = 11
) (
    input  wire                                  clk,
    input  wire                                  rst_n,
    input  wire  [ADDR_BITS:0]                   config_nfft_i,
    input  wire  [(FILTER_ORDER+1)*BITS-1:0]     a_coeffs_i,
    input  wire  [(FILTER_ORDER+1)*BITS-1:0]     b_coeffs_i,
    input  wire                                  start_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic [ADDR_BITS-1:0]                 phase_addr_o,
    input  wire  [PHASE_BITS-1:0]                phase_data_i,
    output logic [PHASE_BITS-1:0]                trig_phase_o,
    input  wire  signed [BITS-1:0]               trig_cos_i,
    input  wire  signed [BITS-1:0]               trig_sin_i,
    iir_freq_resp_engine_if.master               out_if
);

    localparam int N     = FILTER_ORDER;
    localparam int TAP_W = (N + 1 > 1) ? $clog2(N + 1) : 1;
    localparam int ACC_W = 2 * BITS + $clog2(N + 1);
    localparam int EXT_W = ACC_W - 2 * BITS;
    localparam logic [ADDR_BITS:0] NFFT_ONE = (ADDR_BITS + 1)'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_TAP   = 3'd3,
        ST_LAST  = 3'd4,
        ST_OUT   = 3'd5
    } state_t;

    state_t                  state_q;
    logic                    busy_q;
    logic                    done_q;
    logic [ADDR_BITS:0]      nfft_q;
    logic [ADDR_BITS-1:0]    point_cnt_q;
    logic [PHASE_BITS-1:0]   theta_q;
    logic [PHASE_BITS-1:0]   tap_phase_q;
    logic [TAP_W-1:0]        tap_cnt_q;

    logic signed [ACC_W-1:0] nr_q, ni_q, dr_q, di_q;
    logic signed [ACC_W-1:0] nr_d, ni_d, dr_d, di_d;

    logic [BITS-1:0]         num_real_q, num_imag_q, den_real_q, den_imag_q;
    logic                    out_valid_q;

    // Coefficients unpacked per tap
    logic signed [BITS-1:0]  a_tap [0:N];
    logic signed [BITS-1:0]  b_tap [0:N];

    for (genvar k = 0; k <= N; k++) begin : g_unpack
        assign a_tap[k] = a_coeffs_i[k*BITS +: BITS];
        assign b_tap[k] = b_coeffs_i[k*BITS +: BITS];
    end

    logic [TAP_W-1:0]        acc_sel;
    logic                    acc_en;
    logic signed [BITS-1:0]  a_sel, b_sel;
    logic signed [2*BITS-1:0] p_bc, p_bs, p_ac, p_as;

    function automatic logic signed [ACC_W-1:0] ext(input logic signed [2*BITS-1:0] p);
        return {{EXT_W{p[2*BITS-1]}}, p};
    endfunction

    // Scale an accumulator back to BITS: arithmetic shift, then wrap or clamp
    function automatic logic [BITS-1:0] reduce(input logic signed [ACC_W-1:0] acc);
`ifdef SATURATE_EN
        logic signed [ACC_W-1:0] sh;
        logic signed [ACC_W-1:0] sat_max;
        logic signed [ACC_W-1:0] sat_min;
        sat_max = $signed({{(ACC_W-BITS+1){1'b0}}, {(BITS-1){1'b1}}});
        sat_min = $signed({{(ACC_W-BITS+1){1'b1}}, {(BITS-1){1'b0}}});
        sh      = acc >>> FRAC_BITS;
        if (sh > sat_max)
            return {1'b0, {(BITS-1){1'b1}}};
        else if (sh < sat_min)
            return {1'b1, {(BITS-1){1'b0}}};
        else
            return sh[BITS-1:0];
`else
        return acc[FRAC_BITS +: BITS];
`endif
    endfunction

    // Trig results land one cycle after their phase, so the tap being
    // accumulated lags the tap counter by one; LAST picks up tap N.
    always_comb begin
        acc_en  = 1'b0;
        acc_sel = '0;
        if (state_q == ST_LAST) begin
            acc_en  = 1'b1;
            acc_sel = TAP_W'(N);
        end else if (state_q == ST_TAP && tap_cnt_q != '0) begin
            acc_en  = 1'b1;
            acc_sel = tap_cnt_q - TAP_W'(1);
        end
        a_sel = a_tap[acc_sel];
        b_sel = b_tap[acc_sel];
        p_bc  = b_sel * trig_cos_i;
        p_bs  = b_sel * trig_sin_i;
        p_ac  = a_sel * trig_cos_i;
        p_as  = a_sel * trig_sin_i;
        nr_d  = nr_q;
        ni_d  = ni_q;
        dr_d  = dr_q;
        di_d  = di_q;
        if (acc_en) begin
            nr_d = nr_q + ext(p_bc);
            ni_d = ni_q - ext(p_bs);
            dr_d = dr_q + ext(p_ac);
            di_d = di_q - ext(p_as);
        end
    end

    // Sweep sequencer with accumulators and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            nfft_q      <= '0;
            point_cnt_q <= '0;
            theta_q     <= '0;
            tap_phase_q <= '0;
            tap_cnt_q   <= '0;
            nr_q        <= '0;
            ni_q        <= '0;
            dr_q        <= '0;
            di_q        <= '0;
            num_real_q  <= '0;
            num_imag_q  <= '0;
            den_real_q  <= '0;
            den_imag_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        if (config_nfft_i == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            nfft_q      <= config_nfft_i;
                            point_cnt_q <= '0;
                            busy_q      <= 1'b1;
                            state_q     <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    theta_q     <= phase_data_i;
                    tap_phase_q <= '0;
                    tap_cnt_q   <= '0;
                    nr_q        <= '0;
                    ni_q        <= '0;
                    dr_q        <= '0;
                    di_q        <= '0;
                    state_q     <= ST_TAP;
                end
                ST_TAP: begin
                    nr_q        <= nr_d;
                    ni_q        <= ni_d;
                    dr_q        <= dr_d;
                    di_q        <= di_d;
                    tap_phase_q <= tap_phase_q + theta_q;
                    if (tap_cnt_q == TAP_W'(N))
                        state_q <= ST_LAST;
                    else
                        tap_cnt_q <= tap_cnt_q + TAP_W'(1);
                end
                ST_LAST: begin
                    nr_q        <= nr_d;
                    ni_q        <= ni_d;
                    dr_q        <= dr_d;
                    di_q        <= di_d;
                    num_real_q  <= reduce(nr_d);
                    num_imag_q  <= reduce(ni_d);
                    den_real_q  <= reduce(dr_d);
                    den_imag_q  <= reduce(di_d);
                    out_valid_q <= 1'b1;
                    state_q     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_if.out_ready) begin
                        out_valid_q <= 1'b0;
                        if ({1'b0, point_cnt_q} == nfft_q - NFFT_ONE) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            point_cnt_q <= point_cnt_q + ADDR_BITS'(1);
                            state_q     <= ST_FETCH;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign phase_addr_o     = point_cnt_q;
    assign trig_phase_o     = tap_phase_q;
    assign out_if.num_real  = num_real_q;
    assign out_if.num_imag  = num_imag_q;
    assign out_if.den_real  = den_real_q;
    assign out_if.den_imag  = den_imag_q;
    assign out_if.out_valid = out_valid_q;
    assign out_if.point_idx = point_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_iir_freq_resp_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iir_freq_resp_engine
//  Description : Directed bench for iir_freq_resp_engine (N=2, 16-bit, Q13).
//                Exact sin/cos model with 1-cycle latency, phase table model,
//                frequency-response reference model and stream checker.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iir_freq_resp_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] config_nfft;
    logic [47:0] a_coeffs, b_coeffs;
    logic        start;
    logic        busy, done;
    logic [10:0] phase_addr;
    logic [15:0] phase_data;
    logic [15:0] trig_phase;
    logic signed [15:0] trig_cos, trig_sin;

    logic [15:0] ptab [0:2047];

    iir_freq_resp_engine_if #(.BITS(16), .ADDR_BITS(11)) out_if ();

    iir_freq_resp_engine dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .config_nfft_i(config_nfft),
        .a_coeffs_i   (a_coeffs),
        .b_coeffs_i   (b_coeffs),
        .start_i      (start),
        .busy_o       (busy),
        .done_o       (done),
        .phase_addr_o (phase_addr),
        .phase_data_i (phase_data),
        .trig_phase_o (trig_phase),
        .trig_cos_i   (trig_cos),
        .trig_sin_i   (trig_sin),
        .out_if       (out_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference models ----------------
    function automatic logic signed [15:0] trig_val(input logic [15:0] ph, input bit is_sin);
        real ang, v;
        int  iv;
        ang = 2.0 * 3.14159265358979323846 * real'(ph) / 65536.0;
        v   = (is_sin ? $sin(ang) : $cos(ang)) * 8192.0;
        if (v >= 0.0) iv = $rtoi(v + 0.5);
        else          iv = -$rtoi(-v + 0.5);
        return iv[15:0];
    endfunction

    // External units: table read and sin/cos both one cycle late
    always @(posedge clk) begin
        phase_data <= ptab[phase_addr];
        trig_cos   <= trig_val(trig_phase, 1'b0);
        trig_sin   <= trig_val(trig_phase, 1'b1);
    end

    typedef struct {
        logic [15:0] nr, ni, dr, di;
        logic [10:0] idx;
    } res_t;

    function automatic logic [15:0] reduce_m(input longint acc);
        longint sh;
        sh = acc >>> 13;
`ifdef SATURATE_EN
        if (sh > 32767)  sh = 32767;
        if (sh < -32768) sh = -32768;
`endif
        return sh[15:0];
    endfunction

    // H evaluated directly as sums over taps of coef * e^{-jk theta}
    function automatic res_t model_point(input logic [15:0] theta, input logic [10:0] idx);
        longint nr, ni, dr, di, c, s, ak, bk;
        logic [15:0] ph;
        int   phi;
        res_t r;
        nr = 0; ni = 0; dr = 0; di = 0;
        for (int k = 0; k <= 2; k++) begin
            phi = (k * int'(theta)) % 65536;
            ph  = phi[15:0];
            c   = longint'(trig_val(ph, 1'b0));
            s   = longint'(trig_val(ph, 1'b1));
            bk  = longint'($signed(b_coeffs[k*16 +: 16]));
            ak  = longint'($signed(a_coeffs[k*16 +: 16]));
            nr += bk * c;
            ni -= bk * s;
            dr += ak * c;
            di -= ak * s;
        end
        r.nr  = reduce_m(nr);
        r.ni  = reduce_m(ni);
        r.dr  = reduce_m(dr);
        r.di  = reduce_m(di);
        r.idx = idx;
        return r;
    endfunction

    res_t exp_q[$];

    // ---------------- stream checker ----------------
    int          done_cnt  = 0;
    int          done_cyc  = 0;
    int          acc_cnt   = 0;
    int          acc_cyc   = 0;
    int          valid_cnt = 0;
    bit          hold_v    = 1'b0;
    logic [74:0] held;
    logic [15:0] last_nr, last_ni, last_dr, last_di;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v)
                chk("hold_stable",
                    {out_if.out_valid, out_if.num_real, out_if.num_imag, out_if.den_real,
                     out_if.den_imag, out_if.point_idx, phase_addr}, held);
            hold_v = 1'b0;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (out_if.out_valid) begin
                valid_cnt++;
                if (out_if.out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_point", {53'd0, out_if.point_idx}, 64'hffff_ffff);
                    end else begin
                        res_t e;
                        e = exp_q.pop_front();
                        chk("num_real", out_if.num_real, e.nr);
                        chk("num_imag", out_if.num_imag, e.ni);
                        chk("den_real", out_if.den_real, e.dr);
                        chk("den_imag", out_if.den_imag, e.di);
                        chk("point_idx", out_if.point_idx, e.idx);
                    end
                    last_nr = out_if.num_real;
                    last_ni = out_if.num_imag;
                    last_dr = out_if.den_real;
                    last_di = out_if.den_imag;
                    acc_cnt++;
                    acc_cyc = cyc;
                end else begin
                    hold_v = 1'b1;
                    held   = {1'b1, out_if.num_real, out_if.num_imag, out_if.den_real,
                              out_if.den_imag, out_if.point_idx, phase_addr};
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int start_cyc;

    task automatic do_start(input int nfft);
        @(posedge clk); #1;
        config_nfft = nfft[11:0];
        start       = 1'b1;
        start_cyc   = cyc;
        @(posedge clk); #1;
        start       = 1'b0;
    endtask

    task automatic push_exp(input int nfft);
        for (int i = 0; i < nfft; i++)
            exp_q.push_back(model_point(ptab[i], i[10:0]));
    endtask

    task automatic wait_done(input int base, input int maxc);
        int n = 0;
        while (done_cnt == base && n < maxc) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == base) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_acc(input int target, input int maxc);
        int n = 0;
        while (acc_cnt < target && n < maxc) begin
            @(posedge clk);
            n++;
        end
        if (acc_cnt < target) chk("accept_timeout", acc_cnt, target);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        res_t m;
        int   base;
        rst_n           = 1'b0;
        start           = 1'b0;
        config_nfft     = '0;
        out_if.out_ready = 1'b1;
        b_coeffs = {16'h1aa1, 16'hcee9, 16'h1aa1};
        a_coeffs = {16'h1541, 16'hcee9, 16'h2000};
        for (int i = 0; i < 2048; i++) ptab[i] = 16'h0000;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_valid", out_if.out_valid, 1'b0);
        chk("rst_data", {out_if.num_real, out_if.num_imag, out_if.den_real, out_if.den_imag}, 64'd0);
        chk("rst_addr_phase_idx", {phase_addr, trig_phase, out_if.point_idx}, 64'd0);
        rst_n = 1'b1;

        // Zero phase
        ptab[0] = 16'h0000;
        m = model_point(16'h0000, 11'd0);
        chk("model_zero", {m.nr, m.ni, m.dr, m.di}, {16'h042b, 16'h0000, 16'h042a, 16'h0000});
        push_exp(1);
        base = done_cnt;
        do_start(1);
        chk("busy_after_start", busy, 1'b1);
        wait_done(base, 100);
        chk("zero_dut", {last_nr, last_ni, last_dr, last_di}, {16'h042b, 16'h0000, 16'h042a, 16'h0000});
        chk("done_after_accept", done_cyc - acc_cyc, 1);
        chk("point_latency", done_cyc - start_cyc, 8);

        // Quarter turn
        ptab[0] = 16'h4000;
        m = model_point(16'h4000, 11'd0);
        chk("model_quarter", {m.nr, m.ni, m.dr, m.di}, {16'h0000, 16'h3117, 16'h0abf, 16'h3117});
        push_exp(1);
        base = done_cnt;
        do_start(1);
        wait_done(base, 100);
        chk("quarter_dut", {last_nr, last_ni, last_dr, last_di}, {16'h0000, 16'h3117, 16'h0abf, 16'h3117});

        // Multi-point sweep with assorted phases and coefficients
        b_coeffs = {16'hf000, 16'h0c00, 16'h1800};
        a_coeffs = {16'h0800, 16'hd000, 16'h2000};
        ptab[0] = 16'h1000; ptab[1] = 16'h2000; ptab[2] = 16'h5555;
        ptab[3] = 16'h8000; ptab[4] = 16'hc123;
        push_exp(5);
        base = done_cnt;
        do_start(5);
        wait_done(base, 200);
        chk("sweep5_latency", done_cyc - start_cyc, 7 * 5 + 1);
        chk("sweep5_drained", exp_q.size(), 0);

        // Overflow
        b_coeffs = {16'h7fff, 16'h7fff, 16'h7fff};
        a_coeffs = {16'h1541, 16'hcee9, 16'h2000};
        ptab[0] = 16'h0000;
        m = model_point(16'h0000, 11'd0);
`ifdef SATURATE_EN
        chk("model_overflow", m.nr, 16'h7fff);
`else
        chk("model_overflow", m.nr, 16'h7ffd);
`endif
        push_exp(1);
        base = done_cnt;
        do_start(1);
        wait_done(base, 100);
`ifdef SATURATE_EN
        chk("overflow_dut", last_nr, 16'h7fff);
`else
        chk("overflow_dut", last_nr, 16'h7ffd);
`endif
        b_coeffs = {16'h1aa1, 16'hcee9, 16'h1aa1};

        // Backpressure on point 1
        ptab[0] = 16'h0800; ptab[1] = 16'h3000; ptab[2] = 16'h7000; ptab[3] = 16'he000;
        push_exp(4);
        base = done_cnt;
        do_start(4);
        wait_acc(acc_cnt + 1, 100);
        #1 out_if.out_ready = 1'b0;
        begin
            int n = 0;
            while (!out_if.out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        chk("bp_valid_idx", {out_if.out_valid, out_if.point_idx}, {1'b1, 11'd1});
        repeat (10) @(posedge clk);
        #1 out_if.out_ready = 1'b1;
        wait_done(base, 200);
        repeat (5) @(posedge clk);
        chk("bp_single_done", done_cnt - base, 1);
        chk("bp_drained", exp_q.size(), 0);
        chk("bp_busy_low", busy, 1'b0);

        // nfft = 0
        base = valid_cnt;
        do_start(0);
        @(negedge clk);
        chk("nfft0_done", {done, busy}, 2'b10);
        repeat (10) @(posedge clk);
        chk("nfft0_no_valid", valid_cnt - base, 0);

        // Reset during TAP of point 2
        push_exp(4);
        base = acc_cnt;
        do_start(4);
        wait_acc(base + 2, 100);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_outputs", {busy, done, out_if.out_valid, out_if.num_real, out_if.num_imag,
                              out_if.den_real, out_if.den_imag}, 67'd0);
        chk("abort_addr_phase", {phase_addr, trig_phase, out_if.point_idx}, 64'd0);
        exp_q.delete();
        base = done_cnt;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        chk("abort_no_done", done_cnt - base, 0);

        // New sweep after reset starts at point 0
        push_exp(2);
        base = done_cnt;
        do_start(2);
        wait_done(base, 100);
        chk("restart_drained", exp_q.size(), 0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
